// File: rtl/gb_bus_model.sv
// Bus responder for CPU benches: byte memory window, write-capture log FIFO, interrupt controller.
// Latency: reads return one cycle after rd_n low; int_n follows pend/enable one cycle later.
// Backpressure: the log drains on log_valid & log_ready; writes into a full log are dropped and flagged in log_ovf.
module gb_bus_model #(
    parameter int                ADDR_W    = 16,
    parameter int                MEM_AW    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
    parameter int                LOG_DEPTH = 16,
    parameter int                NUM_IRQ   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                rd_n,
    input  logic                wr_n,
    input  logic                m1_n,
    input  logic [7:0]          cpu_dout,
    output logic [7:0]          cpu_din,
    output logic                int_n,
    input  logic                ld_en,
    input  logic [MEM_AW-1:0]   ld_addr,
    input  logic [7:0]          ld_data,
    input  logic [NUM_IRQ-1:0]  irq_set,
    input  logic [NUM_IRQ-1:0]  irq_en,
    output logic [NUM_IRQ-1:0]  irq_pend,
    output logic                log_valid,
    input  logic                log_ready,
    output logic [ADDR_W-1:0]   log_addr,
    output logic [7:0]          log_data,
    output logic                log_ovf,
    output logic [15:0]         fetch_cnt
);

    localparam int MEM_DEPTH = 1 << MEM_AW;
    localparam int LP_W      = $clog2(LOG_DEPTH);

    // Window bounds carried one bit wider so BASE_ADDR + depth cannot wrap.
    localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(MEM_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } log_ent_t;

    function automatic logic [ADDR_W-1:0] vec_addr(input int i);
        return ADDR_W'(32'h40 + 8 * i);
    endfunction

    logic [7:0]          mem [MEM_DEPTH];
    log_ent_t            log_q [LOG_DEPTH];
    logic [ADDR_W:0]     addr_ext;
    logic                hit;
    logic [MEM_AW-1:0]   idx;
    logic                wr_q;
    logic                m1_q;
    logic                wr_evt;
    logic                fetch_evt;
    logic [LP_W:0]       wr_ptr;
    logic [LP_W:0]       rd_ptr;
    logic [LP_W:0]       count;
    logic                full;
    logic                pop;
    logic                push_ok;
    logic [NUM_IRQ-1:0]  clr;
    logic                found;
    log_ent_t            head;

    assign addr_ext  = {1'b0, addr};
    assign hit       = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
    assign idx       = MEM_AW'(addr - BASE_ADDR);
    assign wr_evt    = wr_q & ~wr_n;
    assign fetch_evt = m1_q & ~m1_n;

    // Previous-cycle strobe levels for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= 1'b1;
            m1_q <= 1'b1;
        end else begin
            wr_q <= wr_n;
            m1_q <= m1_n;
        end
    end

    // Opcode-fetch counter, free-running wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= 16'd0;
        end else if (fetch_evt) begin
            fetch_cnt <= fetch_cnt + 16'd1;
        end
    end

    // Memory is not reset so preloads survive; CPU write issued last so it wins on a shared index.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
        if (wr_evt && hit) begin
            mem[idx] <= cpu_dout;
        end
    end

    // Registered read data; holds while rd_n is high, open bus reads as FF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_din <= 8'hFF;
        end else if (!rd_n) begin
            cpu_din <= hit ? mem[idx] : 8'hFF;
        end
    end

    // Write log: pointers carry an extra wrap bit so full and empty are distinct.
    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == (LP_W+1)'(LOG_DEPTH));
    assign log_valid = (wr_ptr != rd_ptr);
    assign pop       = log_valid & log_ready;
    assign push_ok   = wr_evt & (~full | pop);
    assign head      = log_q[rd_ptr[LP_W-1:0]];
    assign log_addr  = log_valid ? head.addr : '0;
    assign log_data  = log_valid ? head.data : 8'h00;

    // Log storage, written only when the entry is accepted.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            log_q[wr_ptr[LP_W-1:0]] <= '{addr: addr, data: cpu_dout};
        end
    end

    // Log pointers and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            log_ovf <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_evt && full && !pop) begin
                log_ovf <= 1'b1;
            end
        end
    end

    // Vector fetch acknowledges the lowest enabled pending channel whose vector matches.
    always_comb begin
        clr   = '0;
        found = 1'b0;
        if (!m1_n && !rd_n) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (!found && irq_pend[i] && irq_en[i] && (addr == vec_addr(i))) begin
                    clr[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

    // Pending bits (set beats clear) and registered interrupt line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_pend <= '0;
            int_n    <= 1'b1;
        end else begin
            irq_pend <= (irq_pend & ~clr) | irq_set;
            int_n    <= ~|(irq_pend & irq_en);
        end
    end

endmodule

// File: tb/tb_gb_bus_model.sv
// Directed bench for gb_bus_model: cycle vector table for reads/writes/fetch counting,
// hand-written sequences for log overflow, full-FIFO push+pop, reset and interrupts.
module tb_gb_bus_model;

    localparam int ADDR_W    = 16;
    localparam int MEM_AW    = 8;
    localparam int LOG_DEPTH = 16;
    localparam int NUM_IRQ   = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [ADDR_W-1:0]  addr;
    logic               rd_n, wr_n, m1_n;
    logic [7:0]         cpu_dout;
    logic [7:0]         cpu_din;
    logic               int_n;
    logic               ld_en;
    logic [MEM_AW-1:0]  ld_addr;
    logic [7:0]         ld_data;
    logic [NUM_IRQ-1:0] irq_set, irq_en, irq_pend;
    logic               log_valid, log_ready, log_ovf;
    logic [ADDR_W-1:0]  log_addr;
    logic [7:0]         log_data;
    logic [15:0]        fetch_cnt;

    always #5 clk = ~clk;

    gb_bus_model #(
        .ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .BASE_ADDR(16'h0000),
        .LOG_DEPTH(LOG_DEPTH), .NUM_IRQ(NUM_IRQ)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din), .int_n(int_n),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .irq_set(irq_set), .irq_en(irq_en), .irq_pend(irq_pend),
        .log_valid(log_valid), .log_ready(log_ready), .log_addr(log_addr),
        .log_data(log_data), .log_ovf(log_ovf), .fetch_cnt(fetch_cnt)
    );

    typedef struct {
        logic [15:0] addr;
        logic        rd_n;
        logic        wr_n;
        logic        m1_n;
        logic [7:0]  dout;
        logic [7:0]  exp_din;
        logic [15:0] exp_fetch;
        logic        exp_lv;
    } vec_t;

    vec_t vt[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        addr     = a;
        cpu_dout = d;
        wr_n     = 1'b0;
        tick();
        wr_n     = 1'b1;
        tick();
    endtask

    task automatic m1_read(input logic [15:0] a);
        addr = a;
        rd_n = 1'b0;
        m1_n = 1'b0;
        tick();
        rd_n = 1'b1;
        m1_n = 1'b1;
    endtask

    task automatic pop_one;
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
    endtask

    initial begin
        int          n;
        logic [15:0] la;
        logic [7:0]  ldv;

        // addr, rd_n, wr_n, m1_n, dout, exp cpu_din, exp fetch_cnt, exp log_valid
        vt.push_back('{16'h0000, 1'b0, 1'b1, 1'b0, 8'h00, 8'h3E, 16'd1, 1'b0});
        vt.push_back('{16'h0000, 1'b1, 1'b1, 1'b1, 8'h00, 8'h3E, 16'd1, 1'b0});
        vt.push_back('{16'h0001, 1'b0, 1'b1, 1'b0, 8'h00, 8'h42, 16'd2, 1'b0});
        vt.push_back('{16'h0001, 1'b1, 1'b1, 1'b1, 8'h00, 8'h42, 16'd2, 1'b0});
        vt.push_back('{16'h0002, 1'b0, 1'b1, 1'b0, 8'h00, 8'h47, 16'd3, 1'b0});
        vt.push_back('{16'h0002, 1'b1, 1'b1, 1'b1, 8'h00, 8'h47, 16'd3, 1'b0});
        vt.push_back('{16'h4000, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 16'd3, 1'b0});
        vt.push_back('{16'h4000, 1'b1, 1'b1, 1'b1, 8'h00, 8'hFF, 16'd3, 1'b0});
        vt.push_back('{16'h4000, 1'b1, 1'b0, 1'b1, 8'hAA, 8'hFF, 16'd3, 1'b1});
        vt.push_back('{16'h4000, 1'b1, 1'b1, 1'b1, 8'hAA, 8'hFF, 16'd3, 1'b1});
        vt.push_back('{16'h0000, 1'b0, 1'b1, 1'b1, 8'h00, 8'h3E, 16'd3, 1'b1});
        vt.push_back('{16'h0000, 1'b1, 1'b1, 1'b1, 8'h00, 8'h3E, 16'd3, 1'b1});
        vt.push_back('{16'h0010, 1'b1, 1'b0, 1'b1, 8'h77, 8'h3E, 16'd3, 1'b1});
        vt.push_back('{16'h0010, 1'b1, 1'b0, 1'b1, 8'h77, 8'h3E, 16'd3, 1'b1});
        vt.push_back('{16'h0010, 1'b1, 1'b0, 1'b1, 8'h77, 8'h3E, 16'd3, 1'b1});
        vt.push_back('{16'h0010, 1'b1, 1'b1, 1'b1, 8'h77, 8'h3E, 16'd3, 1'b1});
        vt.push_back('{16'h0010, 1'b0, 1'b1, 1'b1, 8'h00, 8'h77, 16'd3, 1'b1});
        vt.push_back('{16'h0010, 1'b1, 1'b1, 1'b1, 8'h00, 8'h77, 16'd3, 1'b1});
        vt.push_back('{16'h0000, 1'b0, 1'b1, 1'b0, 8'h00, 8'h3E, 16'd4, 1'b1});
        vt.push_back('{16'h0000, 1'b0, 1'b1, 1'b0, 8'h00, 8'h3E, 16'd4, 1'b1});
        vt.push_back('{16'h0000, 1'b1, 1'b1, 1'b1, 8'h00, 8'h3E, 16'd4, 1'b1});

        rst = 1'b1; addr = '0; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; cpu_dout = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; irq_set = '0; irq_en = '0; log_ready = 1'b0;
        tick();
        tick();
        check("rst cpu_din",   32'(cpu_din),   32'hFF);
        check("rst int_n",     32'(int_n),     32'h1);
        check("rst irq_pend",  32'(irq_pend),  32'h0);
        check("rst log_valid", 32'(log_valid), 32'h0);
        check("rst log_addr",  32'(log_addr),  32'h0);
        check("rst log_data",  32'(log_data),  32'h0);
        check("rst log_ovf",   32'(log_ovf),   32'h0);
        check("rst fetch_cnt", 32'(fetch_cnt), 32'h0);
        rst = 1'b0;

        // Preload
        ld_en = 1'b1;
        ld_addr = 8'h00; ld_data = 8'h3E; tick();
        ld_addr = 8'h01; ld_data = 8'h42; tick();
        ld_addr = 8'h02; ld_data = 8'h47; tick();
        ld_en = 1'b0;

        // Cycle vector table
        for (int i = 0; i < vt.size(); i++) begin
            addr = vt[i].addr; rd_n = vt[i].rd_n; wr_n = vt[i].wr_n;
            m1_n = vt[i].m1_n; cpu_dout = vt[i].dout;
            tick();
            check($sformatf("vec%0d cpu_din", i),   32'(cpu_din),   32'(vt[i].exp_din));
            check($sformatf("vec%0d fetch_cnt", i), 32'(fetch_cnt), 32'(vt[i].exp_fetch));
            check($sformatf("vec%0d log_valid", i), 32'(log_valid), 32'(vt[i].exp_lv));
        end
        rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;

        // Log holds the miss write then exactly one entry for the held strobe
        check("log head0 addr", 32'(log_addr), 32'h4000);
        check("log head0 data", 32'(log_data), 32'hAA);
        pop_one();
        check("log head1 valid", 32'(log_valid), 32'h1);
        check("log head1 addr",  32'(log_addr),  32'h0010);
        check("log head1 data",  32'(log_data),  32'h77);
        pop_one();
        check("log empty after 2", 32'(log_valid), 32'h0);

        // 17 writes into a 16-deep log
        for (int k = 0; k < 17; k++) begin
            do_write(16'(16'h0100 + k), 8'(k));
            if (k == 15) check("ovf before 17th", 32'(log_ovf), 32'h0);
        end
        check("ovf after 17th", 32'(log_ovf), 32'h1);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("drain%0d valid", k), 32'(log_valid), 32'h1);
            check($sformatf("drain%0d addr", k),  32'(log_addr),  32'(16'h0100 + k));
            check($sformatf("drain%0d data", k),  32'(log_data),  32'(k));
            pop_one();
        end
        check("drain empty", 32'(log_valid), 32'h0);
        check("ovf sticky",  32'(log_ovf),   32'h1);

        // Reset clears the log state but keeps memory contents
        rst = 1'b1;
        tick();
        check("rst2 log_ovf", 32'(log_ovf), 32'h0);
        rst = 1'b0;
        addr = 16'h0000; rd_n = 1'b0;
        tick();
        rd_n = 1'b1;
        check("preload survives rst", 32'(cpu_din), 32'h3E);

        // Full log with simultaneous push and pop
        for (int k = 0; k < 16; k++) do_write(16'(16'h0200 + k), 8'(8'h80 + k));
        check("full no ovf", 32'(log_ovf), 32'h0);
        addr = 16'h0300; cpu_dout = 8'h55; wr_n = 1'b0; log_ready = 1'b1;
        tick();
        wr_n = 1'b1; log_ready = 1'b0;
        tick();
        check("push+pop no ovf", 32'(log_ovf),  32'h0);
        check("push+pop head",   32'(log_addr), 32'h0201);
        n = 0; la = '0; ldv = '0;
        while (log_valid && n < 40) begin
            la = log_addr; ldv = log_data;
            pop_one();
            n++;
        end
        check("push+pop count",     32'(n),   32'd16);
        check("push+pop last addr", 32'(la),  32'h0300);
        check("push+pop last data", 32'(ldv), 32'h55);

        // Interrupts
        irq_en = 5'b11111;
        irq_set = 5'b00001; tick();
        check("int_n latency", 32'(int_n), 32'h1);
        irq_set = 5'b00100; tick();
        irq_set = 5'b00000;
        check("pend 00101", 32'(irq_pend), 32'h05);
        check("int_n asserted", 32'(int_n), 32'h0);
        m1_read(16'h0040);
        check("clear ch0", 32'(irq_pend), 32'h04);
        tick();
        check("int_n still low", 32'(int_n), 32'h0);
        m1_read(16'h0044);
        check("no-vector fetch keeps pend", 32'(irq_pend), 32'h04);
        addr = 16'h0050; rd_n = 1'b0; tick(); rd_n = 1'b1;
        check("non-M1 read keeps pend", 32'(irq_pend), 32'h04);
        m1_read(16'h0050);
        check("clear ch2", 32'(irq_pend), 32'h00);
        tick();
        check("int_n released", 32'(int_n), 32'h1);
        irq_set = 5'b00010; tick();
        m1_read(16'h0048);
        irq_set = 5'b00000;
        check("set wins over clear", 32'(irq_pend), 32'h02);
        irq_en = 5'b00000;
        tick(); tick();
        check("disabled int_n", 32'(int_n), 32'h1);
        m1_read(16'h0048);
        check("disabled not cleared", 32'(irq_pend), 32'h02);
        irq_en = 5'b00010;
        tick(); tick();
        check("re-enabled int_n", 32'(int_n), 32'h0);

        // Asynchronous reset mid-operation
        rst = 1'b1;
        #1;
        check("async rst int_n",     32'(int_n),     32'h1);
        check("async rst irq_pend",  32'(irq_pend),  32'h0);
        check("async rst fetch_cnt", 32'(fetch_cnt), 32'h0);
        check("async rst cpu_din",   32'(cpu_din),   32'hFF);
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
